aes_dec_ctrl: RTL and testbench

Control FSM for the AES inverse-cipher datapath and the complement of the encryption controller. It accepts decryption opcodes, sequences the inverse S-box, inverse round, and round-key selection through a shared datapath, and pulses a ready strobe when the plaintext is valid. It sits between the instruction front end and aes_dec, the S-box in inverse mode, and the round-key store.

---
 rtl/aes_pkg.sv | 35 +++
 rtl/aes_dec_ctrl_rnd_cnt.sv | 26 ++
 rtl/aes_dec_ctrl.sv | 129 ++++++++++++
 tb/tb_aes_dec_ctrl.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES decryption control slice.
// Optional feature macro: AES_DEC_IMC_EN (enables the standalone AESIMC opcode).
package aes_pkg;

  localparam int unsigned AES_NR = 10;

  typedef enum logic [2:0] {
    NOOP       = 3'd0,
    AESDEC     = 3'd1,
    AESDECLAST = 3'd2,
    AESDECFULL = 3'd3,
    AESIMC     = 3'd4
  } opcode;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    ISBOX  = 3'd2,
    IROUND = 3'd3,
    IMC    = 3'd4,
    DONE   = 3'd5
  } dec_state_t;

  // Opcodes the decryption controller will accept; NOOP is not "legal" but is
  // silently ignored rather than flagged.
  function automatic logic op_legal(input opcode op);
    logic ok;
    ok = (op == AESDEC) || (op == AESDECLAST) || (op == AESDECFULL);
`ifdef AES_DEC_IMC_EN
    ok = ok || (op == AESIMC);
`endif
    return ok;
  endfunction

endpackage

// File: rtl/aes_dec_ctrl_rnd_cnt.sv
// Loadable round down-counter; saturates at zero instead of wrapping.
module aes_dec_rnd_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  // Load has priority over decrement; decrement stops at zero.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec && (cnt != '0))
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/aes_dec_ctrl.sv
// Control FSM sequencing the AES inverse-cipher datapath.
// Optional feature macro: AES_DEC_IMC_EN (standalone InvMixColumns via AESIMC).
module aes_dec_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NR = AES_NR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  opcode      opcode_i,
  output logic       load_o,
  output logic       init_rnd_o,
  output logic       inv_sub_o,
  output logic       round_en_o,
  output logic       final_rnd_o,
  output logic       imc_only_o,
  output logic       key_sel_o,
  output logic [3:0] rk_idx_o,
  output logic       busy_o,
  output logic       plain_ready_o,
  output logic       err_o
);

  localparam int unsigned CW = $clog2(NR + 1);

  dec_state_t    state, state_nxt;
  opcode         op_q;
  logic          err_q;
  logic          accept;
  logic          cnt_load, cnt_dec, rnd_zero;
  logic [CW-1:0] rnd_q;

  assign accept   = start_i && (state == IDLE) && op_legal(opcode_i) && !rst;
  assign load_o   = accept;
  assign cnt_load = accept && (opcode_i == AESDECFULL);
  assign cnt_dec  = (state == IROUND) && (op_q == AESDECFULL);

  aes_dec_rnd_cnt #(.W(CW)) u_rnd_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (CW'(NR - 1)),
    .dec      (cnt_dec),
    .cnt      (rnd_q),
    .zero     (rnd_zero)
  );

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          case (opcode_i)
            AESDEC, AESDECLAST: state_nxt = ISBOX;
            AESDECFULL:         state_nxt = INIT;
`ifdef AES_DEC_IMC_EN
            AESIMC:             state_nxt = IMC;
`endif
            default:            state_nxt = IDLE;
          endcase
        end
      end
      INIT:   state_nxt = ISBOX;
      ISBOX:  state_nxt = IROUND;
      IROUND: state_nxt = ((op_q == AESDECFULL) && !rnd_zero) ? ISBOX : DONE;
`ifdef AES_DEC_IMC_EN
      IMC:    state_nxt = DONE;
`endif
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, latched opcode and the registered illegal-opcode pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_q  <= NOOP;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept)
        op_q <= opcode_i;
      else if (state == DONE)
        op_q <= NOOP;
      err_q <= start_i && (state == IDLE) && (opcode_i != NOOP) && !op_legal(opcode_i);
    end
  end

  // Moore output decode from state, latched opcode and round count.
  always_comb begin
    init_rnd_o    = 1'b0;
    inv_sub_o     = 1'b0;
    round_en_o    = 1'b0;
    final_rnd_o   = 1'b0;
    imc_only_o    = 1'b0;
    key_sel_o     = 1'b0;
    rk_idx_o      = '0;
    plain_ready_o = 1'b0;
    busy_o        = (state != IDLE);
    err_o         = err_q;
    case (state)
      INIT: begin
        init_rnd_o = 1'b1;
        key_sel_o  = 1'b1;
        rk_idx_o   = 4'(NR);
      end
      ISBOX: inv_sub_o = 1'b1;
      IROUND: begin
        round_en_o = 1'b1;
        if (op_q == AESDECFULL) begin
          key_sel_o   = 1'b1;
          rk_idx_o    = 4'(rnd_q);
          final_rnd_o = rnd_zero;
        end else begin
          final_rnd_o = (op_q == AESDECLAST);
        end
      end
`ifdef AES_DEC_IMC_EN
      IMC: imc_only_o = 1'b1;
`endif
      DONE: plain_ready_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aes_dec_ctrl.sv
// Randomized self-checking bench for aes_dec_ctrl against a trace-based model.
// Honors AES_DEC_IMC_EN the same way as the design.
module tb_aes_dec_ctrl;
  import aes_pkg::*;

  localparam int unsigned NRT = 10;

  logic       clk = 1'b0;
  logic       rst, start_i;
  opcode      opcode_i;
  logic       load_o, init_rnd_o, inv_sub_o, round_en_o, final_rnd_o, imc_only_o;
  logic       key_sel_o, busy_o, plain_ready_o, err_o;
  logic [3:0] rk_idx_o;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  aes_dec_ctrl #(.NR(NRT)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .opcode_i      (opcode_i),
    .load_o        (load_o),
    .init_rnd_o    (init_rnd_o),
    .inv_sub_o     (inv_sub_o),
    .round_en_o    (round_en_o),
    .final_rnd_o   (final_rnd_o),
    .imc_only_o    (imc_only_o),
    .key_sel_o     (key_sel_o),
    .rk_idx_o      (rk_idx_o),
    .busy_o        (busy_o),
    .plain_ready_o (plain_ready_o),
    .err_o         (err_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output vector: init sub rnd fin imc ks rk[3:0] busy rdy err
  function automatic logic [12:0] mk(input int init, input int sub, input int rnd, input int fin,
                                     input int imc, input int ks, input int rk, input int busy,
                                     input int rdy, input int err);
    logic [12:0] v;
    v = {init[0], sub[0], rnd[0], fin[0], imc[0], ks[0], rk[3:0], busy[0], rdy[0], err[0]};
    return v;
  endfunction

  function automatic logic [12:0] observed();
    return {init_rnd_o, inv_sub_o, round_en_o, final_rnd_o, imc_only_o, key_sel_o,
            rk_idx_o, busy_o, plain_ready_o, err_o};
  endfunction

  function automatic bit imc_enabled();
`ifdef AES_DEC_IMC_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit legal(input opcode op);
    return (op == AESDEC) || (op == AESDECLAST) || (op == AESDECFULL) ||
           ((op == AESIMC) && imc_enabled());
  endfunction

  logic [12:0] q[$];

  // Queue the per-cycle outputs an accepted request produces, starting the cycle after acceptance.
  task automatic push_trace(input opcode op);
    if (op == NOOP) return;
    if (!legal(op)) begin
      q.push_back(mk(0,0,0,0,0,0,0,0,0,1));
      return;
    end
    case (op)
      AESDEC, AESDECLAST: begin
        q.push_back(mk(0,1,0,0,0,0,0,1,0,0));
        q.push_back(mk(0,0,1,(op == AESDECLAST) ? 1 : 0,0,0,0,1,0,0));
      end
      AESDECFULL: begin
        q.push_back(mk(1,0,0,0,0,1,NRT,1,0,0));
        for (int r = NRT - 1; r >= 0; r--) begin
          q.push_back(mk(0,1,0,0,0,0,0,1,0,0));
          q.push_back(mk(0,0,1,(r == 0) ? 1 : 0,0,1,r,1,0,0));
        end
      end
      default: q.push_back(mk(0,0,0,0,1,0,0,1,0,0));
    endcase
    q.push_back(mk(0,0,0,0,0,0,0,1,1,0));
  endtask

  initial begin
    logic [12:0] cur;
    logic        rst_prev;
    logic        exp_load;
    rst      = 1'b1;
    start_i  = 1'b0;
    opcode_i = NOOP;
    @(posedge clk);
    #1;
    rst_prev = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (rst_prev) begin
        q.delete();
        cur = '0;
      end else if (q.size() > 0) begin
        cur = q.pop_front();
      end else begin
        cur = '0;
      end

      rst      = (cyc < 2) || ($urandom_range(0, 149) == 0);
      start_i  = ($urandom_range(0, 1) == 1);
      opcode_i = opcode'(3'($urandom_range(0, 7)));
      if ($urandom_range(0, 3) == 0) opcode_i = AESDECFULL;

      exp_load = 1'b0;
      if (!rst && !cur[2] && start_i) begin
        exp_load = legal(opcode_i);
        push_trace(opcode_i);
      end

      @(negedge clk);
      check("outs", 32'(observed()), 32'(cur));
      check("load", 32'(load_o), 32'(exp_load));
      rst_prev = rst;
      @(posedge clk);
      #1;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
